// File: rtl/jtframe_ps2_tx.sv
// Host-to-device PS/2 byte transmitter driving open-drain PS2_CLK/PS2_DATA through output enables.
// Optional input glitch filter enabled by defining JTFRAME_PS2_TX_FILTER_EN.
module jtframe_ps2_tx #(
  parameter int INHIBIT_CYCLES = 4800,
  parameter int TIMEOUT_CYCLES = 960000,
  parameter int FILTER         = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_err,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);
  localparam int IW = $clog2(INHIBIT_CYCLES);
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_INHIBIT = 3'd1;
  localparam logic [2:0] S_REQ     = 3'd2;
  localparam logic [2:0] S_SHIFT   = 3'd3;
  localparam logic [2:0] S_ACK     = 3'd4;
  localparam logic [2:0] S_WAIT    = 3'd5;
  localparam logic [2:0] S_ERR     = 3'd6;

  logic [1:0]    r_clk_sync, r_dat_sync;
  logic          w_kclk, w_kdat, w_fall, w_timeout;
  logic          r_kclk_d;
  logic [2:0]    r_state;
  logic [8:0]    r_shift;
  logic [3:0]    r_bit_cnt;
  logic [IW-1:0] r_inh_cnt;
  logic [TW-1:0] r_to_cnt;

  // Idle bus level is high, so synchronizers reset to 1 to avoid a false edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_clk_sync <= 2'b11;
      r_dat_sync <= 2'b11;
    end else begin
      r_clk_sync <= {r_clk_sync[0], ps2_clk_in};
      r_dat_sync <= {r_dat_sync[0], ps2_data_in};
    end
  end

`ifdef JTFRAME_PS2_TX_FILTER_EN
  localparam int FW = $clog2(FILTER + 1);
  logic [1:0]          w_sync;
  logic [1:0]          r_filt;
  logic [1:0][FW-1:0]  r_fcnt;

  assign w_sync = {r_dat_sync[1], r_clk_sync[1]};

  // A line only follows the synchronizer after FILTER consecutive differing samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_filt <= 2'b11;
      r_fcnt <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (w_sync[i] == r_filt[i]) begin
          r_fcnt[i] <= '0;
        end else if (r_fcnt[i] == FW'(FILTER - 1)) begin
          r_filt[i] <= w_sync[i];
          r_fcnt[i] <= '0;
        end else begin
          r_fcnt[i] <= r_fcnt[i] + 1'b1;
        end
      end
    end
  end

  assign w_kclk = r_filt[0];
  assign w_kdat = r_filt[1];
`else
  logic w_unused_filter;
  assign w_unused_filter = (FILTER > 0);
  assign w_kclk = r_clk_sync[1];
  assign w_kdat = r_dat_sync[1];
`endif

  always_ff @(posedge clk) begin
    if (rst) r_kclk_d <= 1'b1;
    else     r_kclk_d <= w_kclk;
  end

  assign w_fall = r_kclk_d & ~w_kclk;

  // Timer starts at 1 in REQ so the error pulse (one cycle after entering ERR)
  // lands exactly TIMEOUT_CYCLES after the clock line is released.
  assign w_timeout = (r_state == S_SHIFT || r_state == S_ACK || r_state == S_WAIT) &&
                     (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_inh_cnt   <= '0;
      r_to_cnt    <= '0;
      tx_busy     <= 1'b0;
      tx_done     <= 1'b0;
      tx_err      <= 1'b0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      tx_err  <= 1'b0;
      if (r_state == S_SHIFT || r_state == S_ACK || r_state == S_WAIT)
        r_to_cnt <= r_to_cnt + 1'b1;
      if (w_timeout) begin
        r_state <= S_ERR;
      end else begin
        case (r_state)
          S_IDLE: if (tx_start) begin
            r_shift    <= {~^tx_data, tx_data};
            r_inh_cnt  <= '0;
            ps2_clk_oe <= 1'b1;
            tx_busy    <= 1'b1;
            r_state    <= S_INHIBIT;
          end
          S_INHIBIT: begin
            if (r_inh_cnt == IW'(INHIBIT_CYCLES - 2)) begin
              ps2_data_oe <= 1'b1;
              r_state     <= S_REQ;
            end else begin
              r_inh_cnt <= r_inh_cnt + 1'b1;
            end
          end
          S_REQ: begin
            ps2_clk_oe <= 1'b0;
            r_bit_cnt  <= '0;
            r_to_cnt   <= TW'(1);
            r_state    <= S_SHIFT;
          end
          S_SHIFT: if (w_fall) begin
            if (r_bit_cnt == 4'd9) begin
              ps2_data_oe <= 1'b0;
              r_state     <= S_ACK;
            end else begin
              ps2_data_oe <= ~r_shift[r_bit_cnt];
            end
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
          S_ACK: if (w_fall) begin
            r_state <= w_kdat ? S_ERR : S_WAIT;
          end
          S_WAIT: if (w_kclk && w_kdat) begin
            tx_done <= 1'b1;
            tx_busy <= 1'b0;
            r_state <= S_IDLE;
          end
          S_ERR: begin
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            tx_err      <= 1'b1;
            tx_busy     <= 1'b0;
            r_state     <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_jtframe_ps2_tx.sv
// Directed bench for jtframe_ps2_tx: a PS/2 device model clocks frames, a scoreboard holds expected bits/outcome.
module tb_jtframe_ps2_tx;
  localparam int INH = 4800;
  localparam int TO  = 2000;
  localparam int FLT = 8;
  localparam int HP  = 20;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy, tx_done, tx_err;
  logic       ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;
  logic       dev_clk_low, dev_data_low;

  typedef struct { logic [10:0] smp; logic ok; } exp_t;
  exp_t exp_q[$];

  int n_vec = 0, n_fail = 0;
  int n_done = 0, n_err = 0;
  int cyc = 0, rel_cyc = 0, err_cyc = 0;
  logic prev_clk_oe = 1'b0;
  logic [10:0] last_smp;

  jtframe_ps2_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO), .FILTER(FLT)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_start(tx_start),
    .tx_busy(tx_busy), .tx_done(tx_done), .tx_err(tx_err),
    .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe)
  );

  always #5 clk = ~clk;

  assign ps2_clk_in  = ~(ps2_clk_oe  | dev_clk_low);
  assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (tx_done) n_done <= n_done + 1;
    if (tx_err) begin
      n_err   <= n_err + 1;
      err_cyc <= cyc;
    end
    if (prev_clk_oe && !ps2_clk_oe) rel_cyc <= cyc;
    prev_clk_oe <= ps2_clk_oe;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic start_tx(input logic [7:0] d);
    @(negedge clk);
    tx_data  = d;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
  endtask

  // Device: samples on each rising edge (start bit before the first fall), optional ack.
  task automatic dev_frame(input int max_falls, input bit ack, input bit inj);
    int k;
    last_smp = '0;
    for (k = 0; k < 20000 && ps2_clk_oe; k++) @(negedge clk);
    if (ps2_clk_oe) check("release_wait", 32'(ps2_clk_oe), 32'd0);
    repeat (HP) @(negedge clk);
    last_smp[0] = ps2_data_in;
    for (int i = 0; i < 10; i++) begin
      if (i >= max_falls) return;
      dev_clk_low = 1'b1;
      if (inj && i == 3) begin
        tx_data  = 8'hFF;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        repeat (HP - 1) @(negedge clk);
      end else begin
        repeat (HP) @(negedge clk);
      end
      dev_clk_low = 1'b0;
      last_smp[i+1] = ps2_data_in;
      repeat (HP) @(negedge clk);
    end
    if (max_falls <= 10) return;
    if (ack) dev_data_low = 1'b1;
    repeat (HP / 2) @(negedge clk);
    dev_clk_low = 1'b1;
    repeat (HP) @(negedge clk);
    dev_clk_low = 1'b0;
    repeat (HP) @(negedge clk);
    dev_data_low = 1'b0;
  endtask

  task automatic wait_outcome(input int base, input int bound);
    for (int k = 0; k < bound && (n_done + n_err) == base; k++) @(negedge clk);
    repeat (5) @(negedge clk);
  endtask

  task automatic full_frame(input logic [7:0] d, input bit ack, input bit inj, input bit meas);
    exp_t e;
    int d0, e0, k, dpos;
    e.smp = {1'b1, ~^d, d, 1'b0};
    e.ok  = ack;
    exp_q.push_back(e);
    d0 = n_done; e0 = n_err;
    start_tx(d);
    if (meas) begin
      check("busy_cycle1", 32'(tx_busy), 32'd1);
      check("clkoe_cycle1", 32'(ps2_clk_oe), 32'd1);
      k = 1; dpos = 0;
      while (ps2_clk_oe && k < 10000) begin
        if (ps2_data_oe && dpos == 0) dpos = k;
        k++;
        @(negedge clk);
      end
      check("inhibit_len", 32'(k - 1), 32'(INH));
      check("dataoe_rise_cycle", 32'(dpos), 32'(INH));
      check("clk_release_cycle", 32'(k), 32'(INH + 1));
    end
    dev_frame(11, ack, inj);
    wait_outcome(d0 + e0, 400);
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check("frame_bits", 32'(last_smp), 32'(e.smp));
      check("done_pulses", 32'(n_done - d0), 32'(e.ok));
      check("err_pulses", 32'(n_err - e0), 32'(!e.ok));
    end
    check("busy_after", 32'(tx_busy), 32'd0);
  endtask

  initial begin
    int d0, e0;
    rst = 1'b1; tx_data = '0; tx_start = 1'b0;
    dev_clk_low = 1'b0; dev_data_low = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_outs", 32'({tx_busy, tx_done, tx_err, ps2_clk_oe, ps2_data_oe}), 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // 0xED with ack, inhibit timing measured
    full_frame(8'hED, 1'b1, 1'b0, 1'b1);
    check("ed_bits_literal", 32'(last_smp), 32'h7DA);

    // 0x00 without ack
    full_frame(8'h00, 1'b0, 1'b0, 1'b0);
    check("noack_parity", 32'(last_smp[9]), 32'd1);
    check("noack_lines", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);

    // device stops after 4 bits -> timeout
    d0 = n_done; e0 = n_err;
    start_tx(8'h5A);
    dev_frame(4, 1'b1, 1'b0);
    wait_outcome(d0 + e0, TO + 500);
    check("to_err", 32'(n_err - e0), 32'd1);
    check("to_done", 32'(n_done - d0), 32'd0);
    check("to_latency", 32'(err_cyc - rel_cyc), 32'(TO));
    check("to_lines", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);

    // 0xFF start mid-frame ignored
    full_frame(8'h3C, 1'b1, 1'b1, 1'b0);

    // reset during bit 5, then a clean 0xF4
    d0 = n_done; e0 = n_err;
    start_tx(8'hA5);
    dev_frame(5, 1'b1, 1'b0);
    repeat (5) @(negedge clk);
    check("pre_rst_busy", 32'(tx_busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_outs", 32'({tx_busy, tx_done, tx_err, ps2_clk_oe, ps2_data_oe}), 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("midrst_pulses", 32'((n_done - d0) + (n_err - e0)), 32'd0);
    full_frame(8'hF4, 1'b1, 1'b0, 1'b0);

    // 3-cycle clock glitch right after the start bit
    start_tx(8'h01);
    dev_frame(0, 1'b0, 1'b0);
    check("glitch_pre", 32'(ps2_data_oe), 32'd1);
    dev_clk_low = 1'b1;
    repeat (3) @(negedge clk);
    dev_clk_low = 1'b0;
    repeat (HP) @(negedge clk);
`ifdef JTFRAME_PS2_TX_FILTER_EN
    check("glitch_filtered", 32'(ps2_data_oe), 32'd1);
`else
    check("glitch_advances", 32'(ps2_data_oe), 32'd0);
`endif
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
